arb2x4_rr: RTL and testbench
============================

ARB2X4_RR -- requirements
Module: arb2x4_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of each requester and of the output.
REQ-002 SHALL have parameter FAIR, default 1; 1 = round-robin, 0 = fixed priority with requester 0 highest.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 I0  input  WIDTH  requester-0 data.
REQ-006 V0  input  1  requester-0 valid.
REQ-007 R0  output  1  requester-0 ready; transfer when V0 and R0 are both high at a rising edge.
REQ-008 I1, V1, R1  same as REQ-005..007 for requester 1.
REQ-009 O  output  WIDTH  registered output data.
REQ-010 OV  output  1  output valid.
REQ-011 ORDY  input  1  downstream ready; output transfer when OV and ORDY are both high.
REQ-012 S  output  1  select of the most recently accepted transfer (0 = I0, 1 = I1).

Function
REQ-013 SHALL have two states: EMPTY (OV=0) and FULL (OV=1).
REQ-014 Can-accept condition: state EMPTY, or state FULL with ORDY=1 in the same cycle.
REQ-015 When can-accept is false, R0 and R1 SHALL both be 0.
REQ-016 When can-accept is true, exactly one requester SHALL be granted, and only if at least one of V0/V1 is high.
REQ-017 Grant rule: only one valid -> that requester; both valid with FAIR=1 -> the requester not named by the last-grant pointer LG; both valid with FAIR=0 -> requester 0.
REQ-018 R0/R1 SHALL be combinational from V0, V1, state, ORDY and LG; at most one SHALL be high in any cycle.
REQ-019 On an accepted transfer, the next edge SHALL load O with the granted data, set S and LG to the granted index, and set state FULL; latency from input accept to OV=1 is 1 cycle.
REQ-020 FULL with ORDY=1 and no request present SHALL go to EMPTY on the next edge; O and S hold their values.
REQ-021 FULL with ORDY=0 SHALL hold O, OV, S and LG unchanged (stall); the data SHALL NOT be dropped or overwritten.
REQ-022 Simultaneous output drain and input accept SHALL remain FULL with the new data, sustaining one transfer per cycle.
REQ-023 The data path SHALL be the 2:1 mux (I0 when grant=0, I1 when grant=1), feeding the O register.
REQ-024 Holding V high with the request not granted SHALL never cause loss; it is served no later than the second accept opportunity with FAIR=1.

Reset
REQ-025 When RESET is high at an edge: state EMPTY, OV=0, O=0, S=0, LG=1 (so requester 0 wins the first contention).
REQ-026 While RESET is high, R0 and R1 SHALL be 0; reset mid-transfer discards the buffered word.
REQ-027 RESET SHALL take precedence over all simultaneous handshakes.

Structure
REQ-028 The grant-index encoding (GRANT_I0=0, GRANT_I1=1) and state encoding (EMPTY=0, FULL=1) SHALL live in the shared package; WIDTH is not a package constant.
REQ-029 The data mux SHALL be one instance of the existing Mux2x4 sub-module (WIDTH=4) with S driven by the current grant; the arbiter logic, state and output registers stay in arb2x4_rr.

Verification
REQ-030 Reset: assert RESET for 2 cycles with V0=V1=1 -> R0=R1=0, OV=0, O=0 throughout; first cycle after release -> R0=1, R1=0.
REQ-031 Contention, FAIR=1, ORDY=1, V0=V1=1, I0=4'h3, I1=4'hC held for 4 cycles -> O sequence 3,C,3,C with OV=1 from cycle 2, and S toggling 0,1,0,1.
REQ-032 Stall: FULL with O=4'hA, ORDY=0 for 3 cycles while V1=1, I1=4'h5 -> O stays A, R1=0; ORDY=1 -> R1=1 and O=5 on the next cycle.
REQ-033 Drain to empty: single V0 transfer of 4'h7, then V0=V1=0 with ORDY=1 -> OV=1 for one cycle, then OV=0 with O still 7.
REQ-034 FAIR=0, V0=V1=1 for 3 cycles, ORDY=1 -> R0=1 every cycle, R1=0 throughout, O=I0.
REQ-035 Reset mid-stall: FULL, ORDY=0, RESET pulsed for 1 cycle -> OV=0 next cycle and the buffered word never appears with OV=1.

Source files
------------

// File: rtl/arb2x4_rr_pkg.sv
// Shared encodings and the grant-selection rule for the two-input round-robin arbiter.
package arb2x4_rr_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic GRANT_I0 = 1'b0;
    localparam logic GRANT_I1 = 1'b1;

    // With both requesters valid, round-robin picks the one that did not win last time.
    function automatic logic pick_grant(input logic v0, input logic v1,
                                        input logic lg, input logic fair);
        if (v0 && !v1)
            return GRANT_I0;
        if (v1 && !v0)
            return GRANT_I1;
        if (!fair)
            return GRANT_I0;
        return (lg == GRANT_I1) ? GRANT_I0 : GRANT_I1;
    endfunction

endpackage

// File: rtl/arb2x4_rr_mux.sv
// Two-input data multiplexer: O follows I0 when S=0 and I1 when S=1.
module Mux2x4 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             S,
    output logic [WIDTH-1:0] O
);

    assign O = S ? I1 : I0;

endmodule

// File: rtl/arb2x4_rr.sv
// Two-requester arbiter feeding a single-entry output register with valid/ready flow control.
module arb2x4_rr
    import arb2x4_rr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int FAIR  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I0,
    input  logic             V0,
    output logic             R0,
    input  logic [WIDTH-1:0] I1,
    input  logic             V1,
    output logic             R1,
    output logic [WIDTH-1:0] O,
    output logic             OV,
    input  logic             ORDY,
    output logic             S
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             s_q, s_d;
    logic             lg_q, lg_d;

    logic             can_accept;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] mux_o;

    // The register frees up in the same cycle it drains, so a full buffer can still accept.
    assign can_accept = !RESET && ((state_q == ST_EMPTY) || ORDY);
    assign grant      = pick_grant(V0, V1, lg_q, (FAIR != 0));
    assign accept     = can_accept && (V0 || V1);

    assign R0 = accept && (grant == GRANT_I0);
    assign R1 = accept && (grant == GRANT_I1);

    Mux2x4 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .I0(I0),
        .I1(I1),
        .S (grant),
        .O (mux_o)
    );

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        s_d     = s_q;
        lg_d    = lg_q;
        if (accept) begin
            state_d = ST_FULL;
            o_d     = mux_o;
            s_d     = grant;
            lg_d    = grant;
        end else if ((state_q == ST_FULL) && ORDY) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_EMPTY;
            o_q     <= '0;
            s_q     <= GRANT_I0;
            lg_q    <= GRANT_I1;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            s_q     <= s_d;
            lg_q    <= lg_d;
        end
    end

    assign O  = o_q;
    assign OV = (state_q == ST_FULL);
    assign S  = s_q;

endmodule

// File: tb/tb_arb2x4_rr.sv
// Bench for arb2x4_rr: round-robin and fixed-priority instances share stimulus and are checked against a cycle model.
module tb_arb2x4_rr;

    logic       clk;
    logic       rst;
    logic [3:0] i0, i1;
    logic       v0, v1, ordy;

    logic       r0 [2];
    logic       r1 [2];
    logic [3:0] o  [2];
    logic       ov [2];
    logic       s  [2];

    int n_total = 0;
    int n_pass  = 0;

    // Model state per instance: index 0 is FAIR=1, index 1 is FAIR=0.
    int       m_cnt [2] = '{0, 0};
    logic [3:0] m_o [2] = '{4'h0, 4'h0};
    int       m_s   [2] = '{0, 0};
    int       m_lg  [2] = '{1, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    arb2x4_rr #(.WIDTH(4), .FAIR(1)) dut_rr (
        .CLK(clk), .RESET(rst),
        .I0(i0), .V0(v0), .R0(r0[0]),
        .I1(i1), .V1(v1), .R1(r1[0]),
        .O(o[0]), .OV(ov[0]), .ORDY(ordy), .S(s[0])
    );

    arb2x4_rr #(.WIDTH(4), .FAIR(0)) dut_fp (
        .CLK(clk), .RESET(rst),
        .I0(i0), .V0(v0), .R0(r0[1]),
        .I1(i1), .V1(v1), .R1(r1[1]),
        .O(o[1]), .OV(ov[1]), .ORDY(ordy), .S(s[1])
    );

    // Returns the requester that must be granted now, or -1 when nobody may transfer.
    function automatic int exp_grant(input int k);
        if (rst) return -1;
        if (m_cnt[k] == 1 && !ordy) return -1;
        if (!v0 && !v1) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (k == 1) return 0;
        return (m_lg[k] == 1) ? 0 : 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int g;
            g = exp_grant(k);
            if (rst) begin
                m_cnt[k] <= 0;
                m_o[k]   <= 4'h0;
                m_s[k]   <= 0;
                m_lg[k]  <= 1;
            end else if (g >= 0) begin
                m_cnt[k] <= 1;
                m_o[k]   <= (g == 0) ? i0 : i1;
                m_s[k]   <= g;
                m_lg[k]  <= g;
            end else if (m_cnt[k] == 1 && ordy) begin
                m_cnt[k] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int g;
            g = exp_grant(k);
            check($sformatf("model_r0[%0d]", k), int'(r0[k]), int'(g == 0));
            check($sformatf("model_r1[%0d]", k), int'(r1[k]), int'(g == 1));
            check($sformatf("model_ov[%0d]", k), int'(ov[k]), m_cnt[k]);
            check($sformatf("model_o[%0d]", k),  int'(o[k]),  int'(m_o[k]));
            check($sformatf("model_s[%0d]", k),  int'(s[k]),  m_s[k]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [10:0] tbl [0:11] = '{
        {1'b1, 1'b1, 1'b1, 4'h1, 4'h2},
        {1'b1, 1'b1, 1'b0, 4'h3, 4'h4},
        {1'b1, 1'b1, 1'b1, 4'h5, 4'h6},
        {1'b0, 1'b1, 1'b1, 4'h7, 4'h8},
        {1'b1, 1'b0, 1'b0, 4'h9, 4'hA},
        {1'b1, 1'b1, 1'b1, 4'hB, 4'hC},
        {1'b0, 1'b0, 1'b1, 4'hD, 4'hE},
        {1'b1, 1'b1, 1'b1, 4'hF, 4'h0},
        {1'b1, 1'b1, 1'b1, 4'h2, 4'h1},
        {1'b0, 1'b0, 1'b0, 4'h4, 4'h4},
        {1'b1, 1'b0, 1'b1, 4'h6, 4'h5},
        {1'b0, 1'b0, 1'b1, 4'h0, 4'h0}
    };

    initial begin
        logic [10:0] vec;
        logic [3:0]  seq [4];
        seq[0] = 4'h3; seq[1] = 4'hC; seq[2] = 4'h3; seq[3] = 4'hC;

        // Reset held with both requesters active.
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; i0 = 4'h3; i1 = 4'hC; ordy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            #1;
            for (int k = 0; k < 2; k++) begin
                check("rst_r0", int'(r0[k]), 0);
                check("rst_r1", int'(r1[k]), 0);
                check("rst_ov", int'(ov[k]), 0);
                check("rst_o",  int'(o[k]),  0);
            end
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("first_r0", int'(r0[k]), 1);
            check("first_r1", int'(r1[k]), 0);
        end

        // Contention: round-robin alternates, fixed priority always takes requester 0.
        for (int c = 0; c < 4; c++) begin
            cyc();
            #1;
            check("rr_o",  int'(o[0]),  int'(seq[c]));
            check("rr_s",  int'(s[0]),  c % 2);
            check("rr_ov", int'(ov[0]), 1);
            check("fp_o",  int'(o[1]),  3);
            check("fp_r0", int'(r0[1]), 1);
            check("fp_r1", int'(r1[1]), 0);
        end

        // Stall with A buffered, requester 1 waiting with 5.
        v0 = 1'b1; v1 = 1'b0; i0 = 4'hA;
        cyc();
        ordy = 1'b0; v0 = 1'b0; v1 = 1'b1; i1 = 4'h5;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_r1", int'(r1[0]), 0);
            cyc();
            check("stall_o", int'(o[0]), 4'hA);
            check("stall_ov", int'(ov[0]), 1);
        end
        ordy = 1'b1;
        #1;
        check("unstall_r1", int'(r1[0]), 1);
        cyc();
        check("unstall_o", int'(o[0]), 4'h5);
        check("unstall_s", int'(s[0]), 1);

        // Single transfer of 7 then drain to empty.
        v0 = 1'b1; v1 = 1'b0; i0 = 4'h7;
        cyc();
        check("drain_ov1", int'(ov[0]), 1);
        check("drain_o1",  int'(o[0]),  4'h7);
        v0 = 1'b0;
        cyc();
        check("drain_ov0", int'(ov[0]), 0);
        check("drain_o0",  int'(o[0]),  4'h7);

        // Reset pulse while stalled discards the buffered word.
        v0 = 1'b1; i0 = 4'h9;
        cyc();
        v0 = 1'b0; ordy = 1'b0;
        cyc();
        check("pre_rst_o", int'(o[0]), 4'h9);
        rst = 1'b1;
        cyc();
        check("mid_rst_ov", int'(ov[0]), 0);
        check("mid_rst_o",  int'(o[0]),  0);
        rst = 1'b0; ordy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            check("post_rst_ov", int'(ov[0]), 0);
        end

        // Mixed directed vectors, checked by the cycle model.
        for (int n = 0; n < 12; n++) begin
            vec  = tbl[n];
            v0   = vec[10];
            v1   = vec[9];
            ordy = vec[8];
            i0   = vec[7:4];
            i1   = vec[3:0];
            cyc();
        end
        v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
        cyc();
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
